// File: rtl/trap_seq.sv
// Machine-trap entry sequencer: round-robin hart pick, then flush -> CSR commit -> PC redirect.
// Optional build macro TRAP_VECTORED_EN enables vectored-mode handler addressing.
`timescale 1ns/1ps

`ifndef XLEN
`define XLEN 32
`endif
`ifndef HART_ID_W
`define HART_ID_W 2
`endif

module trap_seq #(
    parameter int NHART   = 4,
    parameter int CAUSE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NHART-1:0]           irq_req,
    input  logic [NHART*CAUSE_W-1:0]   irq_cause,
    input  logic [NHART*`XLEN-1:0]     hart_pc,
    input  logic [`XLEN-1:0]           mtvec,
    output logic                       flush_req,
    output logic [`HART_ID_W-1:0]      flush_hart,
    input  logic                       flush_ack,
    output logic                       csr_we,
    output logic [`HART_ID_W-1:0]      csr_hart,
    output logic [`XLEN-1:0]           csr_mepc,
    output logic [`XLEN-1:0]           csr_mcause,
    output logic                       redirect_valid,
    output logic [`HART_ID_W-1:0]      redirect_hart,
    output logic [`XLEN-1:0]           redirect_pc,
    input  logic                       mret_valid,
    input  logic [`HART_ID_W-1:0]      mret_hart,
    output logic [NHART-1:0]           inflight,
    output logic                       busy
);

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        COMMIT,
        REDIRECT
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [`HART_ID_W-1:0]   cur_hart;
    logic [`HART_ID_W-1:0]   rr_ptr;
    logic [`HART_ID_W-1:0]   win_hart;
    logic [`HART_ID_W-1:0]   scan_idx;
    logic                    win_found;
    logic [CAUSE_W-1:0]      cur_cause;
    logic [`XLEN-1:0]        mepc_q;
    logic [`XLEN-1:0]        base_pc;
    logic [`XLEN-1:0]        target_pc;
    logic [NHART-1:0]        eligible;
    logic [NHART-1:0]        inflight_set;
    logic [NHART-1:0]        inflight_clr;

    // Search upward from the rr pointer; the hart index width makes the wrap implicit.
    always_comb begin
        eligible  = irq_req & ~inflight;
        win_found = 1'b0;
        win_hart  = '0;
        scan_idx  = '0;
        for (int i = 0; i < NHART; i++) begin
            scan_idx = rr_ptr + `HART_ID_W'(i);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_hart  = scan_idx;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (win_found) state_next = FLUSH;
            FLUSH:    if (flush_ack) state_next = COMMIT;
            COMMIT:   state_next = REDIRECT;
            REDIRECT: state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // A COMMIT set is applied after the mret clear so the set wins on a collision.
    always_comb begin
        inflight_set = '0;
        inflight_clr = '0;
        if (state == COMMIT) inflight_set[cur_hart] = 1'b1;
        if (mret_valid)      inflight_clr[mret_hart] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_hart  <= '0;
            cur_cause <= '0;
            mepc_q    <= '0;
            rr_ptr    <= '0;
            inflight  <= '0;
        end else begin
            state    <= state_next;
            inflight <= (inflight & ~inflight_clr) | inflight_set;
            if (state == IDLE && win_found) begin
                cur_hart  <= win_hart;
                cur_cause <= irq_cause[win_hart*CAUSE_W +: CAUSE_W];
                rr_ptr    <= win_hart + `HART_ID_W'(1);
            end
            if (state == FLUSH && flush_ack) begin
                mepc_q <= hart_pc[cur_hart*`XLEN +: `XLEN];
            end
        end
    end

    assign base_pc = {mtvec[`XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign target_pc = (mtvec[1:0] == 2'b01)
                     ? base_pc + {{(`XLEN-CAUSE_W-2){1'b0}}, cur_cause, 2'b00}
                     : base_pc;
`else
    logic unused_mode;
    assign unused_mode = ^mtvec[1:0];
    assign target_pc   = base_pc;
`endif

    // Moore outputs: identifiers and payloads are forced to zero whenever their strobe is low.
    always_comb begin
        flush_req      = 1'b0;
        flush_hart     = '0;
        csr_we         = 1'b0;
        csr_hart       = '0;
        csr_mepc       = '0;
        csr_mcause     = '0;
        redirect_valid = 1'b0;
        redirect_hart  = '0;
        redirect_pc    = '0;
        case (state)
            FLUSH: begin
                flush_req  = 1'b1;
                flush_hart = cur_hart;
            end
            COMMIT: begin
                csr_we     = 1'b1;
                csr_hart   = cur_hart;
                csr_mepc   = mepc_q;
                csr_mcause = {1'b1, {(`XLEN-1-CAUSE_W){1'b0}}, cur_cause};
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_hart  = cur_hart;
                redirect_pc    = target_pc;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule
